// File: rtl/cmp_pkg.sv
// Shared types and constants for the compare_arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, default operand width / requester count,
//           and the bit positions used for packed gt/lt/eq result vectors.
package cmp_pkg;

  localparam int DEF_W     = 2;
  localparam int DEF_N_REQ = 4;

  // 2'd3 is unreachable in normal operation; the FSM recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    RESP    = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  // Result-vector bit positions, shared by the result and LED registers.
  localparam int RES_GT = 0;
  localparam int RES_LT = 1;
  localparam int RES_EQ = 2;
  localparam int RES_W  = 3;

endpackage

// File: rtl/mag_compare2.sv
// Unsigned magnitude comparator for the shared compare slot.
// Latency: combinational, zero cycles.
// Backpressure: none; outputs track inputs continuously.
// Ports: a_i/b_i operands in, gt_o/lt_o/eq_o exactly one high.
module mag_compare2
  import cmp_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         gt_o,
  output logic         lt_o,
  output logic         eq_o
);

  assign gt_o = (a_i > b_i);
  assign lt_o = (a_i < b_i);
  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/compare_arbiter.sv
// Round-robin arbiter sharing one magnitude comparator among N_REQ requesters.
// Latency: grant in cycle t, rsp_valid from t+2, LEDs update the cycle after the rsp handshake.
// Backpressure: RESP holds result stable until rsp_ready; no grant is issued meanwhile.
// Ports: clk/rst (async, active high); req_valid/req_a/req_b in, req_ready one-hot out;
//        rsp_valid/rsp_id/rsp_gt/rsp_lt/rsp_eq out with rsp_ready in;
//        greenled/redled/blueled mirror the last delivered gt/lt/eq.
module compare_arbiter
  import cmp_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int W     = DEF_W,
  parameter int IDW   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*W-1:0]   req_a,
  input  logic [N_REQ*W-1:0]   req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_gt,
  output logic                 rsp_lt,
  output logic                 rsp_eq,
  output logic                 greenled,
  output logic                 redled,
  output logic                 blueled
);

  state_t             state_q;
  logic [IDW-1:0]     ptr_q;
  logic [IDW-1:0]     id_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [RES_W-1:0]   res_q;
  logic [RES_W-1:0]   led_q;
  logic               rsp_valid_q;

  logic               any_vld;
  logic [IDW-1:0]     win_id;
  logic [W-1:0]       a_sel;
  logic [W-1:0]       b_sel;
  logic               cmp_gt;
  logic               cmp_lt;
  logic               cmp_eq;

  // Wrap-around scan starting just past the last winner; the first hit wins.
  always_comb begin : rr_pick
    int               cand;
    logic [N_REQ-1:0] shifted;
    any_vld = 1'b0;
    win_id  = '0;
    cand    = 0;
    shifted = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand    = (int'(ptr_q) + k) % N_REQ;
      shifted = req_valid >> cand;
      if (!any_vld && shifted[0]) begin
        any_vld = 1'b1;
        win_id  = IDW'(cand);
      end
    end
  end

  // Operand slices of the current winner; shifts avoid wide index arithmetic.
  assign a_sel = W'(req_a >> (int'(win_id) * W));
  assign b_sel = W'(req_b >> (int'(win_id) * W));

  // Grant is combinational in IDLE only, and suppressed while reset is held.
  assign req_ready = (state_q == IDLE && any_vld && !rst)
                     ? (N_REQ'(1) << win_id) : '0;

  mag_compare2 #(.W(W)) u_cmp (
    .a_i  (a_q),
    .b_i  (b_q),
    .gt_o (cmp_gt),
    .lt_o (cmp_lt),
    .eq_o (cmp_eq)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= IDW'(N_REQ - 1);  // requester 0 wins first after reset
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      led_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_vld) begin
            a_q     <= a_sel;
            b_q     <= b_sel;
            id_q    <= win_id;
            ptr_q   <= win_id;
            state_q <= COMPARE;
          end
        end
        COMPARE: begin
          res_q[RES_GT] <= cmp_gt;
          res_q[RES_LT] <= cmp_lt;
          res_q[RES_EQ] <= cmp_eq;
          rsp_valid_q   <= 1'b1;
          state_q       <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            led_q       <= res_q;
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_gt    = res_q[RES_GT];
  assign rsp_lt    = res_q[RES_LT];
  assign rsp_eq    = res_q[RES_EQ];
  assign greenled  = led_q[RES_GT];
  assign redled    = led_q[RES_LT];
  assign blueled   = led_q[RES_EQ];

endmodule

// File: tb/tb_compare_arbiter.sv
// Directed bench for compare_arbiter: reset, round robin, backpressure,
// exhaustive compare, mid-transaction reset and dropped requests.
module tb_compare_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_valid;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [3:0] req_ready;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_id;
  logic       rsp_gt, rsp_lt, rsp_eq;
  logic       greenled, redled, blueled;

  int n_cmp = 0;
  int n_err = 0;

  compare_arbiter #(.N_REQ(4), .W(2), .IDW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_gt    (rsp_gt),
    .rsp_lt    (rsp_lt),
    .rsp_eq    (rsp_eq),
    .greenled  (greenled),
    .redled    (redled),
    .blueled   (blueled)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'b0001;
    req_a = 8'b00_00_00_10;
    req_b = 8'b00_00_00_01;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq, greenled, redled, blueled} !== 13'b0) begin
      n_err++;
      $display("FAIL reset_state: got %b expected 0",
               {req_ready, rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq, greenled, redled, blueled});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL first_grant: got %b expected 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid} !== 5'b0) begin
      n_err++;
      $display("FAIL first_compare_cycle: got %b expected 00000", {req_ready, rsp_valid});
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq} !== 6'b1_00_100) begin
      n_err++;
      $display("FAIL first_rsp: got %b expected 100100", {rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq});
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({rsp_valid, greenled, redled, blueled} !== 4'b0100) begin
      n_err++;
      $display("FAIL first_leds: got %b expected 0100", {rsp_valid, greenled, redled, blueled});
    end
  endtask

  task automatic test_round_robin();
    // Results ordered {gt,lt,eq}: A = id, B = 1.
    logic [2:0] exp_res [4];
    logic [3:0] exp_rdy;
    exp_res[0] = 3'b010;
    exp_res[1] = 3'b001;
    exp_res[2] = 3'b100;
    exp_res[3] = 3'b100;
    do_reset();
    req_a = {2'd3, 2'd2, 2'd1, 2'd0};
    req_b = {2'd1, 2'd1, 2'd1, 2'd1};
    rsp_ready = 1'b1;
    for (int i = 0; i <= 14; i++) begin
      @(negedge clk);
      req_valid = (i >= 13) ? 4'b0000 : 4'b1111;
      #1;
      exp_rdy = (i % 3 == 0 && i <= 12) ? 4'(1 << ((i / 3) % 4)) : 4'b0000;
      n_cmp++;
      if (req_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL rr_grant[%0d]: got %b expected %b", i, req_ready, exp_rdy);
      end
      if (i % 3 == 2) begin
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq} !== {1'b1, 2'((i / 3) % 4), exp_res[(i / 3) % 4]}) begin
          n_err++;
          $display("FAIL rr_rsp[%0d]: got %b expected %b", i,
                   {rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq},
                   {1'b1, 2'((i / 3) % 4), exp_res[(i / 3) % 4]});
        end
      end else begin
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
          n_err++;
          $display("FAIL rr_rsp_valid[%0d]: got %b expected 0", i, rsp_valid);
        end
      end
      if (i % 3 == 0 && i > 0) begin
        n_cmp++;
        if ({greenled, redled, blueled} !== exp_res[(i / 3 - 1) % 4]) begin
          n_err++;
          $display("FAIL rr_leds[%0d]: got %b expected %b", i,
                   {greenled, redled, blueled}, exp_res[(i / 3 - 1) % 4]);
        end
      end
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({rsp_valid, greenled, redled, blueled} !== 4'b0010) begin
      n_err++;
      $display("FAIL rr_final_leds: got %b expected 0010", {rsp_valid, greenled, redled, blueled});
    end
  endtask

  task automatic test_back_pressure();
    // Entry: IDLE, ptr = 0, LEDs show lt (red).
    @(negedge clk);
    req_valid = 4'b0100;
    req_a = {2'd0, 2'd3, 2'd0, 2'd0};
    req_b = {2'd0, 2'd3, 2'd0, 2'd0};
    rsp_ready = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL bp_grant: got %b expected 0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    req_a = '0;  // captured operands must be unaffected
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid} !== 5'b0) begin
      n_err++;
      $display("FAIL bp_compare: got %b expected 00000", {req_ready, rsp_valid});
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_valid = 4'b0001;
      rsp_ready = (i == 5);
      #1;
      n_cmp++;
      if ({req_ready, rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq, greenled, redled, blueled}
          !== {4'b0000, 1'b1, 2'd2, 3'b001, 3'b010}) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got %b expected %b", i,
                 {req_ready, rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq, greenled, redled, blueled},
                 {4'b0000, 1'b1, 2'd2, 3'b001, 3'b010});
      end
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, greenled, redled, blueled} !== 8'b0001_0_001) begin
      n_err++;
      $display("FAIL bp_release: got %b expected 00010001",
               {req_ready, rsp_valid, greenled, redled, blueled});
    end
    drain();
  endtask

  task automatic test_exhaustive();
    logic [2:0] exp;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        req_valid = 4'b0010;
        req_a = {4'b0, 2'(a), 2'b0};
        req_b = {4'b0, 2'(b), 2'b0};
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
          n_err++;
          $display("FAIL ex_grant[%0d,%0d]: got %b expected 0010", a, b, req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        exp = {a > b, a < b, a == b};
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq} !== {1'b1, 2'd1, exp}) begin
          n_err++;
          $display("FAIL ex_rsp[%0d,%0d]: got %b expected %b", a, b,
                   {rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq}, {1'b1, 2'd1, exp});
        end
        n_cmp++;
        if ($countones({rsp_gt, rsp_lt, rsp_eq}) != 1) begin
          n_err++;
          $display("FAIL ex_onehot[%0d,%0d]: got %b expected one bit set", a, b,
                   {rsp_gt, rsp_lt, rsp_eq});
        end
      end
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({greenled, redled, blueled} !== 3'b001) begin
      n_err++;
      $display("FAIL ex_leds: got %b expected 001", {greenled, redled, blueled});
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 4'b1000;
    req_a = {2'd3, 2'd0, 2'd0, 2'd0};
    req_b = {2'd1, 2'd0, 2'd0, 2'd0};
    rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b1000) begin
      n_err++;
      $display("FAIL rm_grant: got %b expected 1000", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq, greenled, redled, blueled} !== 13'b0) begin
      n_err++;
      $display("FAIL rm_in_reset: got %b expected 0",
               {req_ready, rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq, greenled, redled, blueled});
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({rsp_valid, greenled, redled, blueled} !== 4'b0) begin
      n_err++;
      $display("FAIL rm_held: got %b expected 0000", {rsp_valid, greenled, redled, blueled});
    end
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b1010;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_err++;
      $display("FAIL rm_regrant: got %b expected 0010", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    n_cmp++;
    if ({rsp_valid, greenled, redled, blueled} !== 4'b0) begin
      n_err++;
      $display("FAIL rm_after: got %b expected 0000", {rsp_valid, greenled, redled, blueled});
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_id} !== 3'b1_01) begin
      n_err++;
      $display("FAIL rm_rsp: got %b expected 101", {rsp_valid, rsp_id});
    end
    drain();
  endtask

  task automatic test_drop_request();
    do_reset();
    @(negedge clk);
    req_valid = 4'b0011;
    req_a = {2'd0, 2'd1, 2'd1, 2'd2};
    req_b = {2'd0, 2'd1, 2'd1, 2'd1};
    rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL drop_grant0: got %b expected 0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0100;  // requester 1 withdraws, requester 2 arrives
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL drop_compare: got %b expected 0000", req_ready);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq} !== {4'b0000, 1'b1, 2'd0, 3'b100}) begin
      n_err++;
      $display("FAIL drop_rsp: got %b expected %b",
               {req_ready, rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq}, {4'b0000, 1'b1, 2'd0, 3'b100});
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL drop_next_grant: got %b expected 0100", req_ready);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_back_pressure();
    test_exhaustive();
    test_reset_mid();
    test_drop_request();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/compare_arbiter.md
# compare_arbiter

Round-robin arbiter and sequencer that shares one 2-bit magnitude comparator among `N_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one request, registers the operands, and registers the greater/less/equal result. It returns that result with the winning requester's ID and mirrors the last delivered result onto the board's red/green/blue LEDs. It sits between the switch/requester logic and the LED outputs.

## Interface
- `N_REQ`, default 4, number of requesters (2..8).
- `W`, default 2, operand width in bits (fixed at 2 for this board; kept as a parameter for the package).
- `IDW`, default 2, requester-ID width, at least $clog2(N_REQ).

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  request pending, one bit per requester.
- `req_a`  in  N_REQ*W  operand A; requester i uses bits [i*W +: W].
- `req_b`  in  N_REQ*W  operand B, same packing as `req_a`.
- `req_ready`  out  N_REQ  one-hot grant; handshake occurs when `req_valid[i]` and `req_ready[i]` are both high.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_id`  out  IDW  index of the requester that owns the result.
- `rsp_gt`, `rsp_lt`, `rsp_eq`  out  1 each  A>B, A<B, A==B.
- `greenled`, `redled`, `blueled`  out  1 each  last delivered gt / lt / eq.

## Operation
- Three-state FSM:
  - IDLE: compute the winner. If any `req_valid` bit is set, assert `req_ready[winner]` combinationally in the same cycle, capture `req_a`/`req_b` slices and the winner ID, set `ptr` to the winner, and go to COMPARE. No valid request: stay in IDLE.
  - COMPARE: the comparator sub-module evaluates the captured operands. Register gt/lt/eq into the result registers and go to RESP.
  - RESP: `rsp_valid`=1. `rsp_id`, `rsp_gt`, `rsp_lt` and `rsp_eq` stay stable until `rsp_ready`=1. On that handshake, update the LED registers from the result and return to IDLE.
- Winner selection: first set `req_valid` bit found scanning from (ptr+1) mod N_REQ upward with wrap-around.
- `req_ready` is 0 in every state other than IDLE, and 0 in IDLE when no request is valid. It is never multi-hot.
- Exactly one of gt/lt/eq is 1 whenever `rsp_valid`=1. Comparison is unsigned, with eq = (A==B).
- A requester dropping `req_valid` before it is granted simply loses arbitration; no state is kept.
- Operands change after the grant: no effect, because they were captured at the grant.
- `rsp_valid` falls in the cycle after the handshake.
- LEDs change only on a response handshake. They hold the previous values while a request is in flight.

## Timing
- Reset values: state=IDLE, `ptr`=N_REQ-1 (so requester 0 wins first), `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_gt`/`rsp_lt`/`rsp_eq`=0, all LEDs=0.
- Reset asserted mid-transaction: any in-flight or undelivered result is discarded and no LED update occurs. The first grant after release goes to the lowest valid index at or above 0.
- Latency: accept in cycle t, `rsp_valid`=1 from cycle t+2.
- With `rsp_ready` held at 1:
  - handshake in cycle t+2;
  - LEDs show the new result in cycle t+3;
  - next grant possible in cycle t+3.
- Maximum throughput is one comparison per 3 cycles.
- Backpressure: RESP holds for any number of cycles, and no new grant is issued during that time.
- `req_ready` is a combinational function of the state, `ptr` and `req_valid`. All other outputs come directly from registers.

## Structure
- Package `cmp_pkg`:
  - FSM state localparams (IDLE=2'd0, COMPARE=2'd1, RESP=2'd2; 2'd3 is illegal and returns to IDLE);
  - default `W` and `N_REQ`;
  - a result-bit index convention: GT=0, LT=1, EQ=2.
- Sub-module `mag_compare2`: purely combinational, inputs a[W-1:0] and b[W-1:0], outputs gt, lt, eq. It is instantiated once and fed from the operand capture registers.
- The round-robin pick lives in the top module as a wrap-around scan loop.

## Test plan
- Reset release with requester 0 valid, A=2'b10, B=2'b01, `rsp_ready`=1: `req_ready`=4'b0001 in the same cycle, `rsp_valid` two cycles later with `rsp_id`=0 and gt=1. `greenled`=1 and the other LEDs 0 the next cycle.
- All four requesters valid continuously: grants go 0,1,2,3,0 with `req_ready` one-hot, one grant every 3 cycles.
- Requester 2 with A=B=2'b11 and `rsp_ready` held 0 for 5 cycles: `rsp_valid`, `rsp_id`=2 and eq=1 stay stable the whole time, `req_ready`=0 throughout, LEDs unchanged until the handshake.
- Exhaustive check of all 16 A/B pairs via requester 1: each response has exactly one of gt/lt/eq set, matching an unsigned compare.
- Requester 3 granted, `rst` pulsed during COMPARE: `rsp_valid` stays 0, LEDs stay 0, the next grant goes to the lowest valid index.
- Requester 1 drops `req_valid` while requester 0 is being served: requester 1 receives no grant and the next grant goes to the next valid index in round-robin order.
